// File: rtl/multiport_regfile.sv
// Decode-stage integer register file: NUM_RD async read ports, NUM_WR sync write ports, busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to readers and masks their busy bit.

module regfile_rd_port #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_WR   = 1,
    parameter int AW       = 5
) (
    input  logic [AW-1:0]                      rd_addr,
    input  logic [NUM_REGS-1:0][XLEN-1:0]      regs,
    input  logic [NUM_REGS-1:0]                busy,
`ifdef REGFILE_BYPASS_EN
    input  logic [NUM_WR-1:0]                  wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]          wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]        wr_data,
`endif
    output logic [XLEN-1:0]                    rd_data,
    output logic                               rd_busy
);
    always_comb begin
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan so the highest-index matching write port wins.
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w] == rd_addr && rd_addr != '0) begin
                rd_data = wr_data[w];
                rd_busy = 1'b0;
            end
        end
`endif
    end
endmodule

module multiport_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]   RD_Addr,
    output logic [NUM_RD*XLEN-1:0]               RD_Data,
    output logic [NUM_RD-1:0]                    RD_Busy,
    input  logic [NUM_WR-1:0]                    WR_En,
    input  logic [NUM_WR*$clog2(NUM_REGS)-1:0]   WR_Addr,
    input  logic [NUM_WR*XLEN-1:0]               WR_Data,
    input  logic                                 Issue_En,
    input  logic [$clog2(NUM_REGS)-1:0]          Issue_Addr,
    output logic                                 Stall,
    input  logic [NUM_RD-1:0]                    RD_Use
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][AW-1:0]       rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0]     rd_data;
    logic [NUM_WR-1:0][AW-1:0]       wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0]     wr_data;

    assign rd_addr = RD_Addr;
    assign RD_Data = rd_data;
    assign wr_addr = WR_Addr;
    assign wr_data = WR_Data;

    // x0 has no storage; the read view splices in constant zeros.
    logic [NUM_REGS-1:1][XLEN-1:0]   regs_q;
    logic [NUM_REGS-1:1]             busy_q;
    logic [NUM_REGS-1:0][XLEN-1:0]   regs_v;
    logic [NUM_REGS-1:0]             busy_v;

    assign regs_v = {regs_q, {XLEN{1'b0}}};
    assign busy_v = {busy_q, 1'b0};

    always_ff @(posedge CLK) begin
        if (RST) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (WR_En[w] && wr_addr[w] == AW'(r)) begin
                        regs_q[r] <= wr_data[w];
                        busy_q[r] <= 1'b0;
                    end
                end
                // Issue after writeback: a newer producer keeps the reg pending.
                if (Issue_En && Issue_Addr == AW'(r))
                    busy_q[r] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rd_port #(
            .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR), .AW(AW)
        ) u_rd (
            .rd_addr (rd_addr[p]),
            .regs    (regs_v),
            .busy    (busy_v),
`ifdef REGFILE_BYPASS_EN
            .wr_en   (WR_En),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
`endif
            .rd_data (rd_data[p]),
            .rd_busy (RD_Busy[p])
        );
    end

    assign Stall = |(RD_Busy & RD_Use);
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile (2 read, 2 write ports); expectations follow REGFILE_BYPASS_EN.

module tb_multiport_regfile;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  RD_Addr;
    logic [63:0] RD_Data;
    logic [1:0]  RD_Busy;
    logic [1:0]  WR_En;
    logic [9:0]  WR_Addr;
    logic [63:0] WR_Data;
    logic        Issue_En;
    logic [4:0]  Issue_Addr;
    logic        Stall;
    logic [1:0]  RD_Use;

    int checks = 0;
    int errors = 0;

    multiport_regfile #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
        .CLK(CLK), .RST(RST),
        .RD_Addr(RD_Addr), .RD_Data(RD_Data), .RD_Busy(RD_Busy),
        .WR_En(WR_En), .WR_Addr(WR_Addr), .WR_Data(WR_Data),
        .Issue_En(Issue_En), .Issue_Addr(Issue_Addr),
        .Stall(Stall), .RD_Use(RD_Use)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        RD_Addr[p*5 +: 5] = a;
    endtask

    task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
        WR_En[w] = 1'b1;
        WR_Addr[w*5 +: 5] = a;
        WR_Data[w*32 +: 32] = d;
    endtask

    task automatic issue(input logic [4:0] a);
        Issue_En = 1'b1;
        Issue_Addr = a;
    endtask

    task automatic idle();
        WR_En = '0;
        Issue_En = 1'b0;
    endtask

    initial begin
        RST = 1'b1; RD_Addr = '0; WR_En = '0; WR_Addr = '0; WR_Data = '0;
        Issue_En = 1'b0; Issue_Addr = '0; RD_Use = '0;

        // 1: reset clears everything
        tick();
        RST = 1'b0;
        RD_Use = 2'b11;
        for (int a = 0; a < 32; a++) begin
            rd(0, 5'(a)); rd(1, 5'(a));
            settle();
            chk($sformatf("rst_data_x%0d", a), RD_Data, 64'h0);
            chk($sformatf("rst_busy_x%0d", a), {62'h0, RD_Busy}, 64'h0);
            chk($sformatf("rst_stall_x%0d", a), {63'h0, Stall}, 64'h0);
        end
        RD_Use = '0;

        // 2: basic write/read, x0 write dropped
        wr(0, 5, 32'hDEADBEEF);
        tick(); idle();
        rd(0, 5); settle();
        chk("wr_x5", {32'h0, RD_Data[31:0]}, 64'hDEADBEEF);
        wr(0, 0, 32'h1);
        tick(); idle();
        rd(0, 0); settle();
        chk("wr_x0_dropped", {32'h0, RD_Data[31:0]}, 64'h0);

        // 3: issue x7, stall until writeback
        issue(7);
        tick(); idle();
        rd(0, 5); rd(1, 7); RD_Use = 2'b10; settle();
        chk("x7_stall", {63'h0, Stall}, 64'h1);
        chk("x7_busy", {62'h0, RD_Busy}, 64'h2);
        RD_Use = 2'b01; settle();
        chk("x7_unused_nostall", {63'h0, Stall}, 64'h0);
        RD_Use = 2'b10;
        wr(0, 7, 32'h42); settle();
        chk("x7_wb_cycle_stall", {63'h0, Stall}, BYP ? 64'h0 : 64'h1);
        chk("x7_wb_cycle_data", {32'h0, RD_Data[63:32]}, BYP ? 64'h42 : 64'h0);
        tick(); idle(); settle();
        chk("x7_after_stall", {63'h0, Stall}, 64'h0);
        chk("x7_after_data", {32'h0, RD_Data[63:32]}, 64'h42);

        // 4: same-cycle write and read of busy x3
        wr(0, 3, 32'h11);
        tick(); idle();
        issue(3);
        tick(); idle();
        rd(0, 3); RD_Use = 2'b01;
        wr(0, 3, 32'hA5); settle();
        chk("x3_fwd_data", {32'h0, RD_Data[31:0]}, BYP ? 64'hA5 : 64'h11);
        chk("x3_fwd_busy", {63'h0, RD_Busy[0]}, BYP ? 64'h0 : 64'h1);
        chk("x3_fwd_stall", {63'h0, Stall}, BYP ? 64'h0 : 64'h1);
        tick(); idle(); settle();
        chk("x3_after_data", {32'h0, RD_Data[31:0]}, 64'hA5);
        chk("x3_after_busy", {63'h0, RD_Busy[0]}, 64'h0);

        // 5: issue and writeback same reg same cycle -> stays busy
        issue(9); wr(0, 9, 32'h77);
        tick(); idle();
        rd(0, 9); settle();
        chk("x9_set_wins_busy", {63'h0, RD_Busy[0]}, 64'h1);
        chk("x9_data", {32'h0, RD_Data[31:0]}, 64'h77);
        wr(1, 9, 32'h88); settle();
        chk("x9_p1_fwd_data", {32'h0, RD_Data[31:0]}, BYP ? 64'h88 : 64'h77);
        chk("x9_p1_fwd_busy", {63'h0, RD_Busy[0]}, BYP ? 64'h0 : 64'h1);
        tick(); idle(); settle();
        chk("x9_p1_clear", {63'h0, RD_Busy[0]}, 64'h0);
        chk("x9_p1_data", {32'h0, RD_Data[31:0]}, 64'h88);

        // dual write to x4: higher port wins, both for storage and forwarding
        rd(1, 4);
        wr(0, 4, 32'h1); wr(1, 4, 32'h2); settle();
        chk("x4_dual_fwd", {32'h0, RD_Data[63:32]}, BYP ? 64'h2 : 64'h0);
        tick(); idle(); settle();
        chk("x4_dual_stored", {32'h0, RD_Data[63:32]}, 64'h2);

        // issue/write to x0 never sets busy or data
        issue(0); wr(1, 0, 32'h5);
        tick(); idle();
        rd(0, 0); settle();
        chk("x0_busy", {63'h0, RD_Busy[0]}, 64'h0);
        chk("x0_data", {32'h0, RD_Data[31:0]}, 64'h0);

        // 6: reset mid-stream discards pending write and busy
        issue(10);
        tick(); idle();
        rd(0, 10); rd(1, 5); RD_Use = 2'b11; settle();
        chk("x10_busy_pre", {62'h0, RD_Busy}, 64'h1);
        wr(0, 10, 32'h55); RST = 1'b1;
        tick(); RST = 1'b0; idle(); settle();
        chk("rst_mid_x10", {32'h0, RD_Data[31:0]}, 64'h0);
        chk("rst_mid_x5", {32'h0, RD_Data[63:32]}, 64'h0);
        chk("rst_mid_busy", {62'h0, RD_Busy}, 64'h0);
        chk("rst_mid_stall", {63'h0, Stall}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
